// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the cache line store.
//   state_t      - controller states (INIT sweep, IDLE service, FILL refill)
//   DEF_*        - default geometry and the constants derived from it
//   words_of()   - words per line for a given line/word width
//   ofs_w()      - word-offset width for a given line/word width
//   byte_merge() - overlay enabled bytes of a new word onto an old word
package cache_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_FILL
    } state_t;

    localparam int DEF_INDEX_W = 10;
    localparam int DEF_LINE_W  = 128;
    localparam int DEF_WORD_W  = 32;
    localparam int DEF_WORDS   = DEF_LINE_W / DEF_WORD_W;
    localparam int DEF_OFS_W   = $clog2(DEF_WORDS);

    // byte_merge works on the widest supported word; callers size-cast
    // their operands in and the result back out.
    localparam int MERGE_W  = 256;
    localparam int MERGE_BE = MERGE_W / 8;

    function automatic int words_of(input int line_w, input int word_w);
        return line_w / word_w;
    endfunction

    function automatic int ofs_w(input int line_w, input int word_w);
        return $clog2(line_w / word_w);
    endfunction

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]  old_word,
        input logic [MERGE_W-1:0]  new_word,
        input logic [MERGE_BE-1:0] be
    );
        logic [MERGE_W-1:0] m;
        m = old_word;
        for (int b = 0; b < MERGE_BE; b++) begin
            if (be[b]) m[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/cache_line_ram.sv
// cache_line_ram: DEPTH x (WORDS*WORD_W) line array.
//   clk, rst      - clock, async active-high reset (read registers only)
//   wr_*          - one write port; wr_mask selects words, wr_be selects
//                   bytes inside each selected word
//   rd_a_*        - registered read port with enable (CPU reads)
//   rd_b_*        - registered read port, free-running (eviction reads)
// Reads return pre-write contents on a same-cycle write to the same line.
module cache_line_ram
    import cache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int WORDS   = DEF_WORDS,
    parameter int WORD_W  = DEF_WORD_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [INDEX_W-1:0]                   wr_index,
    input  logic [WORDS-1:0]                     wr_mask,
    input  logic [WORDS-1:0][WORD_W/8-1:0]       wr_be,
    input  logic [WORDS-1:0][WORD_W-1:0]         wr_data,
    input  logic                                 rd_a_en,
    input  logic [INDEX_W-1:0]                   rd_a_index,
    output logic [WORDS-1:0][WORD_W-1:0]         rd_a_data,
    input  logic [INDEX_W-1:0]                   rd_b_index,
    output logic [WORDS-1:0][WORD_W-1:0]         rd_b_data
);

    localparam int DEPTH = 2 ** INDEX_W;

    logic [WORDS-1:0][WORD_W-1:0] mem [DEPTH];
    logic [WORDS-1:0][WORD_W-1:0] row;
    logic [WORDS-1:0][WORD_W-1:0] merged;

    assign row = mem[wr_index];

    // Build the full new row so the array sees a single whole-line write.
    always_comb begin
        merged = row;
        for (int w = 0; w < WORDS; w++) begin
            if (wr_mask[w])
                merged[w] = WORD_W'(byte_merge(MERGE_W'(row[w]),
                                               MERGE_W'(wr_data[w]),
                                               MERGE_BE'(wr_be[w])));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_index] <= merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_a_data <= '0;
            rd_b_data <= '0;
        end else begin
            if (rd_a_en) rd_a_data <= mem[rd_a_index];
            rd_b_data <= mem[rd_b_index];
        end
    end

endmodule

// File: rtl/cache_line_store.sv
// cache_line_store: cache data array with byte-enabled CPU word access,
// beat-wise refill and a full-line eviction read port.
//   globalclock, reset          - clock, async active-high reset
//   req_*                       - CPU word access (1-cycle read latency)
//   resp_valid, resp_rdata      - read response, rdata holds when idle
//   fill_start/index/valid/data - line refill, word 0 first
//   fill_done                   - pulse the cycle after a line commit
//   busy                        - high during init sweep or refill
//   line_rd_index/data          - registered full-line read, all states
module cache_line_store
    import cache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int WORD_W  = DEF_WORD_W
) (
    input  logic                               globalclock,
    input  logic                               reset,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_we,
    input  logic [INDEX_W-1:0]                 req_index,
    input  logic [ofs_w(LINE_W, WORD_W)-1:0]   req_word,
    input  logic [WORD_W-1:0]                  req_wdata,
    input  logic [WORD_W/8-1:0]                req_be,
    output logic                               resp_valid,
    output logic [WORD_W-1:0]                  resp_rdata,
    input  logic                               fill_start,
    input  logic [INDEX_W-1:0]                 fill_index,
    input  logic                               fill_valid,
    input  logic [WORD_W-1:0]                  fill_data,
    output logic                               fill_done,
    output logic                               busy,
    input  logic [INDEX_W-1:0]                 line_rd_index,
    output logic [LINE_W-1:0]                  line_rd_data
);

    localparam int WORDS = words_of(LINE_W, WORD_W);
    localparam int OFS_W = ofs_w(LINE_W, WORD_W);
    localparam int BE_W  = WORD_W / 8;

    state_t                       state, state_nxt;
    logic [INDEX_W-1:0]           init_cnt;
    logic [OFS_W-1:0]             beat_cnt;
    logic [INDEX_W-1:0]           fill_idx;
    logic [WORDS-1:0][WORD_W-1:0] fill_buf;
    logic                         fill_done_q;
    logic                         resp_valid_q;
    logic [OFS_W-1:0]             word_q;

    logic                         rd_a_en;
    logic                         commit;
    logic                         wr_en;
    logic [INDEX_W-1:0]           wr_index;
    logic [WORDS-1:0]             wr_mask;
    logic [WORDS-1:0][BE_W-1:0]   wr_be;
    logic [WORDS-1:0][WORD_W-1:0] wr_data;
    logic [WORDS-1:0][WORD_W-1:0] rd_a_line;
    logic [WORDS-1:0][WORD_W-1:0] rd_b_line;

    assign req_ready  = (state == ST_IDLE) && !fill_start;
    assign rd_a_en    = req_valid && req_ready && !req_we;
    // WORDS is a power of two, so the last beat is the all-ones offset.
    assign commit     = (state == ST_FILL) && fill_valid && (beat_cnt == '1);
    assign busy       = (state != ST_IDLE);
    assign fill_done  = fill_done_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rd_a_line[word_q];
    assign line_rd_data = rd_b_line;

    always_ff @(posedge globalclock or posedge reset) begin
        if (reset) state <= ST_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_index  = init_cnt;
        wr_mask   = '0;
        wr_be     = '0;
        wr_data   = '0;
        case (state)
            ST_INIT: begin
                wr_en   = 1'b1;
                wr_mask = '1;
                wr_be   = '1;
                if (init_cnt == '1) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (fill_start) begin
                    state_nxt = ST_FILL;
                end else if (req_valid && req_we) begin
                    wr_en             = 1'b1;
                    wr_index          = req_index;
                    wr_mask[req_word] = 1'b1;
                    wr_be[req_word]   = req_be;
                    for (int w = 0; w < WORDS; w++) wr_data[w] = req_wdata;
                end
            end
            ST_FILL: begin
                if (commit) begin
                    // Last beat bypasses the buffer straight into the line.
                    wr_en              = 1'b1;
                    wr_index           = fill_idx;
                    wr_mask            = '1;
                    wr_be              = '1;
                    wr_data            = fill_buf;
                    wr_data[WORDS-1]   = fill_data;
                    state_nxt          = ST_IDLE;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge globalclock or posedge reset) begin
        if (reset) begin
            init_cnt     <= '0;
            beat_cnt     <= '0;
            fill_idx     <= '0;
            fill_buf     <= '0;
            fill_done_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            word_q       <= '0;
        end else begin
            fill_done_q  <= commit;
            resp_valid_q <= rd_a_en;
            if (rd_a_en) word_q <= req_word;
            if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
            if (state == ST_IDLE && fill_start) begin
                fill_idx <= fill_index;
                beat_cnt <= '0;
            end
            if (state == ST_FILL && fill_valid) begin
                fill_buf[beat_cnt] <= fill_data;
                beat_cnt           <= beat_cnt + 1'b1;
            end
        end
    end

    cache_line_ram #(
        .INDEX_W (INDEX_W),
        .WORDS   (WORDS),
        .WORD_W  (WORD_W)
    ) u_ram (
        .clk        (globalclock),
        .rst        (reset),
        .wr_en      (wr_en),
        .wr_index   (wr_index),
        .wr_mask    (wr_mask),
        .wr_be      (wr_be),
        .wr_data    (wr_data),
        .rd_a_en    (rd_a_en),
        .rd_a_index (req_index),
        .rd_a_data  (rd_a_line),
        .rd_b_index (line_rd_index),
        .rd_b_data  (rd_b_line)
    );

endmodule

// File: doc/cache_line_store.md
# cache_line_store

Parametrised cache data array with word-granular, byte-enabled CPU access, beat-wise line refill from RAM and a full-line read port for eviction. Successor to the fixed 1024×128 line store. After reset the array is zeroed by a sequential init sweep rather than in one cycle. Sits between the cache controller (tag/hit logic) and the RAM interface.

## Interface
- INDEX_W, 10, line index width; DEPTH = 2**INDEX_W lines
- LINE_W, 128, line width in bits
- WORD_W, 32, CPU word and refill beat width; WORDS = LINE_W/WORD_W, must be a power of two ≥2
- globalclock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  CPU access request
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_we  in  1  1 = write, 0 = read
- req_index  in  INDEX_W  line index
- req_word  in  log2(WORDS)  word offset within the line
- req_wdata  in  WORD_W  write data
- req_be  in  WORD_W/8  byte enables for writes
- resp_valid  out  1  read data valid
- resp_rdata  out  WORD_W  read data
- fill_start  in  1  begin refill of fill_index
- fill_index  in  INDEX_W  line being refilled; sampled with fill_start
- fill_valid  in  1  refill beat present
- fill_data  in  WORD_W  refill beat, word 0 first
- fill_done  out  1  one-cycle pulse: line committed
- busy  out  1  high in INIT or FILL
- line_rd_index  in  INDEX_W  eviction read index
- line_rd_data  out  LINE_W  eviction read data

## Operation
- States: INIT, IDLE, FILL. Reset forces INIT and clears the init counter, beat counter, line buffer and all output registers.
- INIT: writes zero to line init_cnt each cycle, from 0 up to DEPTH-1, then enters IDLE. Takes exactly DEPTH cycles.
- req_ready = (state==IDLE) && !fill_start. fill_start has priority over a CPU request in the same cycle.
- Accepted read: resp_valid=1 and resp_rdata=word req_word of line req_index on the next cycle. Otherwise resp_valid=0 and resp_rdata holds its last value.
- Accepted write: only the enabled bytes of the addressed word are updated; no response. req_be=0 is a legal no-op.
- A read following a write to the same word on the next cycle returns the new data.
- IDLE + fill_start: latch fill_index, clear beat_cnt, enter FILL.
- FILL: each fill_valid stores fill_data into buffer word beat_cnt, then beat_cnt++. The array is not touched until the last beat.
- On the beat with beat_cnt==WORDS-1, the full line (buffer plus that beat) is written in one cycle. The FSM then returns to IDLE, with fill_done=1 for the following cycle.
- fill_valid outside FILL is ignored. fill_start outside IDLE is ignored.
- line_rd_data: registered read of line line_rd_index, available every cycle in all states. On a same-cycle array write to the same line it returns the pre-write contents.
- Reset mid-FILL or mid-INIT aborts the operation; no partial line is committed, and the FSM restarts INIT.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, fill_done=0, busy=1, line_rd_data=0.
- Read latency is 1 cycle. Fill commit happens on the edge of the last beat, and fill_done is high the cycle after.
- Refill takes WORDS accepted beats, and gaps between beats are allowed. Minimum refill duration is WORDS cycles plus 1 cycle back to IDLE.
- A read accepted in the cycle fill_done is high returns the refilled data.
- First req_ready=1 occurs DEPTH cycles after reset deasserts.

## Structure
- Shared package cache_pkg holds: the state enum (INIT/IDLE/FILL), the derived WORDS and offset-width constants, and a byte-merge function (old word, new word, byte enables → merged word).
- One sub-module, cache_line_ram: DEPTH×LINE_W array with one write port (per-word write mask) and two registered read ports. The FSM, counters and line buffer stay in the top level.

## Test plan
- Reset, then count cycles → busy=1 for exactly 1024 cycles, then req_ready=1; a read of index 1023 word 3 returns 0.
- Write index 5 word 2, data 0xDEADBEEF, be=4'b1111; then write 0x11223344 with be=4'b0101; then read → resp_rdata=0xDE22BE44 one cycle after acceptance.
- fill_start index 7, then beats 0xA0,0xA1,0xA2,0xA3 with one idle cycle between beats 1 and 2 → fill_done pulses once; line_rd_index=7 returns 0x000000A3_000000A2_000000A1_000000A0.
- fill_start and req_valid asserted in the same cycle → req_ready=0 and FILL is entered; the CPU request is accepted only after fill_done.
- Assert reset after 2 refill beats into index 9 (previously 0) → after the next INIT, line 9 reads 0 and fill_done never pulses.
- fill_valid pulses while in IDLE → no array change, resp_valid and fill_done stay 0.
